mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/md_pkg.sv | 16 +
 rtl/md_abs32.sv | 13 +
 rtl/mult_div_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: FSM states, op codes and
// the iteration count of the bit-serial datapath.
package md_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int MD_ITER = 32;
  localparam int CNT_W   = $clog2(MD_ITER);

endpackage

// File: rtl/md_abs32.sv
// 32-bit conditional negate. With cin=1 this is a plain two's-complement
// negate (abs when neg = sign bit); cin lets two instances chain into a
// 64-bit negate (upper half takes cin = "lower half was zero").
module md_abs32 (
  input  logic [31:0] x,
  input  logic        neg,
  input  logic        cin,
  output logic [31:0] y
);

  assign y = neg ? (~x + {31'd0, cin}) : x;

endmodule

// File: rtl/mult_div_unit.sv
// Signed 32x32 multiply / 32/32 divide, one bit per cycle on operand
// magnitudes, with sign correction in a dedicated FIX cycle.
// Latency 34 cycles from start to done; divide by zero completes in 1.
module mult_div_unit
  import md_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dz_q, dz_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      opr_q, opr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0] mag_a, mag_b, fix_lo, fix_hi;
  logic        fix_hi_neg, fix_hi_cin;

  // Operand magnitudes, taken straight off the inputs at acceptance.
  md_abs32 u_abs_a (.x(a), .neg(a[31]), .cin(1'b1), .y(mag_a));
  md_abs32 u_abs_b (.x(b), .neg(b[31]), .cin(1'b1), .y(mag_b));

  // Result sign fix. Low half (product low / quotient) flips on differing
  // signs. High half: remainder follows the dividend sign; for a product it
  // is the upper word of a 64-bit negate, carrying in only if low was zero.
  assign fix_hi_neg = (op_q == OP_DIV) ? sa_q : (sa_q ^ sb_q);
  assign fix_hi_cin = (op_q == OP_DIV) ? 1'b1 : (acc_q[31:0] == 32'd0);

  md_abs32 u_fix_lo (.x(acc_q[31:0]),  .neg(sa_q ^ sb_q), .cin(1'b1),       .y(fix_lo));
  md_abs32 u_fix_hi (.x(acc_q[63:32]), .neg(fix_hi_neg),  .cin(fix_hi_cin), .y(fix_hi));

  // One shift-add multiply step: acc = {partial, multiplier}, shift right.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opr_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // One restoring-divide step: acc = {remainder, quotient}, shift left.
  // The remainder stays below the divisor (<= 2^31), so the shifted
  // remainder always fits in 32 bits.
  logic [63:0] div_sh, div_next;
  logic [32:0] div_diff;
  assign div_sh   = {acc_q[62:0], 1'b0};
  assign div_diff = {1'b0, div_sh[63:32]} - {1'b0, opr_q};
  assign div_next = div_diff[32] ? div_sh : {div_diff[31:0], div_sh[31:1], 1'b1};

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    acc_d   = acc_q;
    opr_d   = opr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op;
          sa_d  = a[31];
          sb_d  = b[31];
          cnt_d = '0;
          if (op == OP_DIV && b == 32'd0) begin
            // Nothing to compute: report immediately, leave hi/lo alone.
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            opr_d   = (op == OP_DIV) ? mag_b : mag_a;
            acc_d   = {32'd0, (op == OP_DIV) ? mag_a : mag_b};
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = (op_q == OP_DIV) ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MD_ITER - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        state_d = ST_DONE;
      end
      default: begin
        dz_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation and clears the results.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= '0;
      opr_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      acc_q   <= acc_d;
      opr_q   <= opr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign div_zero = (state_q == ST_DONE) && dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
